// File: rtl/clk_sched_pkg.sv
// Shared types and constants for the clock-divider scheduler.
// Channel state encoding and default widths live here so the top and channels agree.
package clk_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } ch_state_e;

    localparam int DEF_PW  = 16;
    localparam int DEF_PSW = 32;

    // A period of zero stops the channel.
    localparam int PERIOD_STOP = 0;

endpackage

// File: rtl/clk_sched_chan.sv
// One divider channel: counts base ticks, pulses tick_o and toggles div_clk_o at each wrap.
// New periods are held in a shadow register and only applied at the next wrap boundary.
module clk_sched_chan
    import clk_sched_pkg::*;
#(
    parameter int PW = DEF_PW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          base_tick_i,
    input  logic          wr_en_i,
    input  logic [PW-1:0] wr_period_i,
    output logic          tick_o,
    output logic          div_clk_o,
    output ch_state_e     state_o
);

    ch_state_e     state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] period_q, period_d;
    logic [PW-1:0] shadow_q, shadow_d;
    logic          tick_q, tick_d;
    logic          div_q, div_d;
    logic          wrap;

    // period_q is never zero outside IDLE, so period_q-1 cannot underflow when it matters.
    assign wrap = base_tick_i && (state_q != IDLE) && (cnt_q == period_q - PW'(1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        shadow_d = shadow_q;
        tick_d   = 1'b0;
        div_d    = div_q;

        unique case (state_q)
            IDLE: begin
                if (wr_en_i && (wr_period_i != PW'(PERIOD_STOP))) begin
                    period_d = wr_period_i;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN, PEND: begin
                if (base_tick_i) begin
                    if (wrap) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                        div_d  = !div_q;
                    end else begin
                        cnt_d = cnt_q + PW'(1);
                    end
                end
                if ((state_q == RUN) && wr_en_i) begin
                    shadow_d = wr_period_i;
                    state_d  = PEND;
                end
                // The pending period lands on the wrap; a stop also forces the square wave low.
                if ((state_q == PEND) && wrap) begin
                    period_d = shadow_q;
                    cnt_d    = '0;
                    if (shadow_q == PW'(PERIOD_STOP)) begin
                        state_d = IDLE;
                        div_d   = 1'b0;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            shadow_q <= '0;
            tick_q   <= 1'b0;
            div_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            shadow_q <= shadow_d;
            tick_q   <= tick_d;
            div_q    <= div_d;
        end
    end

    assign tick_o    = tick_q;
    assign div_clk_o = div_q;
    assign state_o   = state_q;

endmodule

// File: rtl/clk_sched.sv
// Bank of programmable clock dividers sharing one prescaler, configured over a valid/ready port.
// Handshake: a write transfers on a clk edge where cfg_valid && cfg_ready; cfg_ready is combinational.
module clk_sched
    import clk_sched_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int CHW      = 2,
    parameter int PRESCALE = 25000000,
    parameter int PSW      = DEF_PSW,
    parameter int PW       = DEF_PW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CHW-1:0]  cfg_ch,
    input  logic [PW-1:0]   cfg_period,
    output logic [N_CH-1:0] tick,
    output logic [N_CH-1:0] div_clk,
    output logic            busy,
    output logic            cfg_err
);

    localparam logic [PSW-1:0] PRE_LAST = PSW'(PRESCALE - 1);

    logic [PSW-1:0]  pre_cnt_q, pre_cnt_d;
    logic            base_tick;
    logic            cfg_err_q, cfg_err_d;
    logic            accept;
    logic            ch_valid;
    logic            ch_pend;
    logic [N_CH-1:0] wr_en;
    ch_state_e       ch_state [N_CH];

    assign base_tick = (pre_cnt_q == PRE_LAST);
    assign pre_cnt_d = base_tick ? '0 : pre_cnt_q + PSW'(1);

    // Out-of-range channels never match, so they read as ready and are flagged instead of written.
    always_comb begin
        ch_valid = 1'b0;
        ch_pend  = 1'b0;
        wr_en    = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_ch == CHW'(i)) begin
                ch_valid = 1'b1;
                ch_pend  = (ch_state[i] == PEND);
            end
        end
        cfg_ready = !ch_pend;
        accept    = cfg_valid && cfg_ready;
        for (int i = 0; i < N_CH; i++) begin
            wr_en[i] = accept && (cfg_ch == CHW'(i));
        end
        cfg_err_d = cfg_err_q || (accept && !ch_valid);
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            busy = busy || (ch_state[i] == PEND);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clk_sched_chan #(
            .PW(PW)
        ) u_chan (
            .clk_i       (clk),
            .rst_i       (reset),
            .base_tick_i (base_tick),
            .wr_en_i     (wr_en[g]),
            .wr_period_i (cfg_period),
            .tick_o      (tick[g]),
            .div_clk_o   (div_clk[g]),
            .state_o     (ch_state[g])
        );
    end

endmodule

// File: tb/tb_clk_sched.sv
// Self-checking bench for clk_sched with PRESCALE=4 and three channels.
// Expected tick edges are queued per channel when a write is accepted and popped as the DUT ticks.
module tb_clk_sched;

    localparam int N_CH     = 3;
    localparam int CHW      = 2;
    localparam int PRESCALE = 4;
    localparam int PSW      = 8;
    localparam int PW       = 16;
    localparam int HORIZON  = 6000;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [CHW-1:0]  cfg_ch;
    logic [PW-1:0]   cfg_period;
    logic [N_CH-1:0] tick;
    logic [N_CH-1:0] div_clk;
    logic            busy;
    logic            cfg_err;

    clk_sched #(
        .N_CH(N_CH), .CHW(CHW), .PRESCALE(PRESCALE), .PSW(PSW), .PW(PW)
    ) dut (
        .clk        (clk),
        .reset      (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .tick       (tick),
        .div_clk    (div_clk),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    // ---------------- clock / reset / edge counter ----------------
    always #10 clk = ~clk;

    // Edge k after reset release sees prescaler count (k-1)%4, so base ticks land on k%4==0.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // ---------------- scoreboard ----------------
    // bit 31 marks the final wrap before a stop; bits 30:0 hold the edge number of the tick.
    logic [31:0] exp_q [N_CH][$];
    logic        exp_div [N_CH];
    int          pend_end [N_CH];
    logic        exp_err;
    int          n_checks;
    int          n_errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int edge_of(input logic [31:0] e);
        return int'(e[30:0]);
    endfunction

    function automatic void sched_from(input int ch, input int start, input int p);
        int b1;
        b1 = (start / PRESCALE + 1) * PRESCALE;
        for (int j = 1; b1 + PRESCALE * (p * j - 1) <= HORIZON; j++)
            exp_q[ch].push_back(32'(b1 + PRESCALE * (p * j - 1)));
    endfunction

    function automatic void apply_write(input int ch, input int w, input int p);
        int k;
        logic [31:0] e;
        if (exp_q[ch].size() == 0) begin
            if (p != 0) sched_from(ch, w, p);
        end else begin
            k = 0;
            while (k < exp_q[ch].size() && edge_of(exp_q[ch][k]) <= w) k++;
            if (k < exp_q[ch].size()) begin
                while (exp_q[ch].size() > k + 1) void'(exp_q[ch].pop_back());
                pend_end[ch] = edge_of(exp_q[ch][k]);
                if (p == 0) begin
                    e = exp_q[ch][k];
                    e[31] = 1'b1;
                    exp_q[ch][k] = e;
                end else begin
                    sched_from(ch, pend_end[ch], p);
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        logic        exp_t;
        logic        exp_busy;
        logic        exp_rdy;
        logic [31:0] e;
        if (!rst) begin
            exp_busy = 1'b0;
            for (int ch = 0; ch < N_CH; ch++) begin
                exp_t = 1'b0;
                if (exp_q[ch].size() != 0 && edge_of(exp_q[ch][0]) == cyc) begin
                    e = exp_q[ch][0];
                    exp_t = 1'b1;
                    exp_div[ch] = e[31] ? 1'b0 : !exp_div[ch];
                    void'(exp_q[ch].pop_front());
                end
                check($sformatf("tick[%0d]", ch), 32'(tick[ch]), 32'(exp_t));
                check($sformatf("div_clk[%0d]", ch), 32'(div_clk[ch]), 32'(exp_div[ch]));
                if (pend_end[ch] > cyc) exp_busy = 1'b1;
            end
            check("busy", 32'(busy), 32'(exp_busy));
            exp_rdy = 1'b1;
            if (int'(cfg_ch) < N_CH) exp_rdy = !(pend_end[int'(cfg_ch)] > cyc);
            check("cfg_ready", 32'(cfg_ready), 32'(exp_rdy));
            check("cfg_err", 32'(cfg_err), 32'(exp_err));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_write(input int ch, input int p, output int acc, output int waits);
        logic r;
        @(posedge clk);
        #2;
        cfg_valid  = 1'b1;
        cfg_ch     = CHW'(ch);
        cfg_period = PW'(p);
        acc   = -1;
        waits = 0;
        for (int n = 0; n < 100; n++) begin
            #2;
            r = cfg_ready;
            @(posedge clk);
            #1;
            if (r) begin
                acc = cyc;
                break;
            end
            waits++;
            #1;
        end
        if (acc < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL write_timeout ch%0d: no accept within 100 cycles", ch);
        end
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic write_sched(input int ch, input int p, output int waits);
        int acc;
        do_write(ch, p, acc, waits);
        if (acc >= 0) begin
            if (ch < N_CH) apply_write(ch, acc, p);
            else           exp_err = 1'b1;
        end
    endtask

    task automatic wait_tick(input int ch);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (tick[ch]) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_tick ch%0d: no tick within 200 cycles", ch);
        end
    endtask

    // ---------------- cfg_ready decode table (ch0 pending, others not) ----------------
    typedef struct {
        logic [CHW-1:0] ch;
        logic           exp_ready;
    } rdy_vec_t;

    rdy_vec_t rdy_tbl [4];

    // ---------------- main sequence ----------------
    initial begin
        int waits;
        bit seen;

        rdy_tbl[0] = '{ch: 2'd0, exp_ready: 1'b0};
        rdy_tbl[1] = '{ch: 2'd1, exp_ready: 1'b1};
        rdy_tbl[2] = '{ch: 2'd2, exp_ready: 1'b1};
        rdy_tbl[3] = '{ch: 2'd3, exp_ready: 1'b1};

        n_checks   = 0;
        n_errors   = 0;
        exp_err    = 1'b0;
        for (int ch = 0; ch < N_CH; ch++) begin
            exp_div[ch]  = 1'b0;
            pend_end[ch] = 0;
        end
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;

        #1;
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_div_clk", 32'(div_clk), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);

        repeat (3) @(negedge clk);
        #3;
        rst = 1'b0;

        // Idle: nothing queued, so the monitor demands silence for 100 cycles.
        repeat (100) @(posedge clk);

        // ch0 at period 3: ticks every 12 clk.
        write_sched(0, 3, waits);
        repeat (40) @(posedge clk);

        // ch1 at period 2.
        write_sched(1, 2, waits);
        repeat (30) @(posedge clk);

        // ch0 retargeted to period 1 just after a tick; stays pending until the next wrap.
        wait_tick(0);
        write_sched(0, 1, waits);
        for (int i = 0; i < 4; i++) begin
            cfg_ch = rdy_tbl[i].ch;
            #1;
            check($sformatf("rdy_tbl[%0d]", i), 32'(cfg_ready), 32'(rdy_tbl[i].exp_ready));
        end
        cfg_ch = 2'd0;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (tick[0]) begin
                seen = 1'b1;
                check("busy_clear_at_tick", 32'(busy), 32'd0);
            end else begin
                check("busy_while_pend", 32'(busy), 32'd1);
                check("ready_while_pend", 32'(cfg_ready), 32'd0);
            end
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL pend_tick: no tick[0] within 40 cycles after retarget");
        end
        repeat (20) @(posedge clk);

        // ch1 stopped: one final tick, then div_clk low and silence.
        write_sched(1, 0, waits);
        repeat (200) @(posedge clk);

        // Out-of-range write completes immediately and latches cfg_err.
        write_sched(3, 5, waits);
        check("oor_waits", 32'(waits), 32'd0);
        repeat (30) @(posedge clk);

        // All channels running, then reset between edges.
        write_sched(1, 2, waits);
        write_sched(2, 5, waits);
        repeat (40) @(posedge clk);
        @(posedge clk);
        #5;
        rst = 1'b1;
        #1;
        check("midrst_tick", 32'(tick), 32'd0);
        check("midrst_div_clk", 32'(div_clk), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cfg_err", 32'(cfg_err), 32'd0);
        for (int ch = 0; ch < N_CH; ch++) begin
            exp_q[ch].delete();
            exp_div[ch]  = 1'b0;
            pend_end[ch] = 0;
        end
        exp_err = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        rst = 1'b0;
        repeat (60) @(posedge clk);

        // Reconfigure after reset.
        write_sched(2, 2, waits);
        repeat (40) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_sched.md
Name: clk_sched

Overview:
Scheduler and configurator for a bank of programmable clock dividers sharing one prescaler. A free-running prescaler produces a base tick. Each of N_CH channels divides that base tick by a runtime-programmed period and emits a one-cycle enable pulse (tick) and a 50% square wave (div_clk). Period changes are written over a valid/ready config port and take effect only at the channel's next wrap boundary, so outputs never glitch.

Parameters:
N_CH, 4, number of divider channels
CHW, 2, width of channel select (must satisfy 2^CHW >= N_CH)
PRESCALE, 25000000, clk cycles per base tick (>=1)
PSW, 32, prescaler counter width
PW, 16, period/counter width per channel

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cfg_valid  in  1  config write request
cfg_ready  out  1  config write can be accepted (combinational)
cfg_ch  in  CHW  target channel
cfg_period  in  PW  new period in base ticks; 0 = stop channel
tick  out  N_CH  per-channel one-clk pulse at each wrap
div_clk  out  N_CH  per-channel square wave, toggles at each wrap
busy  out  1  OR of all channels in PEND
cfg_err  out  1  sticky: write to cfg_ch >= N_CH accepted

Behaviour:
- Reset (async, active-high) values: pre_cnt=0; every channel IDLE with cnt=0, period_q=0, shadow=0; tick=0, div_clk=0, cfg_err=0. busy=0 follows from all channels IDLE.
- Prescaler: pre_cnt counts 0..PRESCALE-1 continuously and wraps to 0. base_tick (internal) is high in the cycle where pre_cnt==PRESCALE-1. PRESCALE=1 gives base_tick every cycle.
- Handshake: a write is accepted when cfg_valid && cfg_ready on a clk edge.
  - cfg_ready = 1 if cfg_ch >= N_CH, else !(state[cfg_ch]==PEND).
  - Out-of-range writes are accepted and dropped, and set cfg_err.
- Per-channel state machine (IDLE, RUN, PEND):
  - IDLE: cnt=0, div_clk=0, no ticks.
    - Accept with period!=0: period_q<=period, cnt<=0, go to RUN.
    - Accept with period==0: no-op, stay IDLE.
  - RUN, on base_tick:
    - if cnt==period_q-1: cnt<=0, tick pulses in the following cycle, div_clk toggles.
    - else cnt<=cnt+1.
    - Accept: shadow<=period, go to PEND. cnt keeps counting with the old period.
  - PEND: counts as RUN with the old period. At the wrap, the tick/toggle fires normally, then:
    - period_q<=shadow, cnt<=0;
    - shadow==0: go to IDLE and force div_clk<=0 in the same edge, overriding the toggle;
    - otherwise go to RUN.
- Timing: tick period = period_q base ticks; div_clk period = 2*period_q base ticks.
- Outputs tick, div_clk, busy and cfg_err are registered, except cfg_ready.
- Simultaneous accept and wrap in RUN: the wrap uses the old period, shadow is captured, state goes to PEND. The new period applies at the following wrap, not the current one.
- Channels are independent. Several channels may tick in the same cycle.
- Counter arithmetic is unsigned PW-bit. cnt never exceeds period_q-1, so there is no overflow path.
- Reset mid-operation: all state and outputs clear immediately. After release, no ticks until channels are reconfigured.

Decomposition:
- Package clk_sched_pkg holds:
  - channel state enum (IDLE, RUN, PEND);
  - default width constants (PW, PSW);
  - localparam PERIOD_STOP = 0.
- Sub-module clk_sched_chan implements one channel: state, cnt, period_q, shadow, tick and div_clk registers, with inputs base_tick, wr_en and wr_period.
- The top holds the prescaler, channel decode, cfg_ready mux, busy reduction and cfg_err, and instantiates N_CH channels in a generate loop.

Test Plan (PRESCALE=4, N_CH=3):
1. Release reset, hold cfg_valid=0 for 100 clk -> tick=0, div_clk=0, busy=0, cfg_ready=1 throughout.
2. Write ch0 period=3 -> tick[0] is 1 clk wide and recurs exactly every 12 clk; div_clk[0] toggles with each tick (period 24 clk); cfg_ready stays 1.
3. ch0 running at period=3, write period=1 mid-interval -> cfg_ready (for cfg_ch=0) and busy are high/low as follows: busy=1 and cfg_ready=0 until the next tick[0]. That tick keeps the 12-clk spacing; subsequent ticks are spaced 4 clk.
4. ch1 running at period=2, write period=0 -> one final tick[1] at the old boundary, then div_clk[1]=0 and no further tick[1] for 200 clk; ch1 returns to IDLE.
5. Write cfg_ch=3 (out of range) with period=5 -> handshake completes in 1 cycle, cfg_err=1 and stays 1, channels 0-2 unaffected.
6. With all channels running, assert reset asynchronously between clk edges -> all outputs go to 0 before the next edge. After release, no ticks until reconfigured, and cfg_err=0.
